// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detect controller: configurable pattern/length/threshold/window
// with run sequencing. Optional SEQDET_CTRL_AUTORESTART_EN keeps the run going after threshold.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_DONE   = 2'b10,
    ST_EXPIRE = 2'b11
  } state_t;

  localparam logic [MAX_LEN-1:0] PAT_RST = {{(MAX_LEN-3){1'b0}}, 3'b101};
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  state_t             state_r;
  logic               match_r;
  logic [CNT_W-1:0]   match_cnt_r;
  logic               busy_r;
  logic               done_r;
  logic               timeout_r;
  // Only MAX_LEN-1 bits are kept; the newest bit comes straight from data_in.
  logic [MAX_LEN-2:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [WIN_W-1:0]   win_cnt_r;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   thresh_r;
  logic [WIN_W-1:0]   window_r;

  logic [MAX_LEN-1:0] hist_next_s;
  logic [LEN_W-1:0]   fill_next_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               hit_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               thr_hit_s;
  logic [WIN_W-1:0]   win_next_s;
  logic               exp_hit_s;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [CNT_W-1:0]   thresh_clamp_s;

  assign match     = match_r;
  assign match_cnt = match_cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign timeout   = timeout_r;
  assign state     = state_r;

  // Detector compare, counter increments and config clamping for the current sample
  always_comb begin
    hist_next_s = {hist_r, data_in};
    if (fill_r < len_r) begin
      fill_next_s = fill_r + LEN_W'(1);
    end else begin
      fill_next_s = fill_r;
    end
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_r) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
    hit_s = (fill_next_s >= len_r) &&
            (((hist_next_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    if (match_cnt_r == CNT_MAX) begin
      cnt_inc_s = match_cnt_r;
    end else begin
      cnt_inc_s = match_cnt_r + CNT_W'(1);
    end
    thr_hit_s  = hit_s && (cnt_inc_s >= thresh_r);
    win_next_s = win_cnt_r + WIN_W'(1);
    exp_hit_s  = (window_r != {WIN_W{1'b0}}) && (win_next_s >= window_r);
    if (cfg_len == {LEN_W{1'b0}}) begin
      len_clamp_s = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_clamp_s = LEN_W'(MAX_LEN);
    end else begin
      len_clamp_s = cfg_len;
    end
    if (cfg_thresh == {CNT_W{1'b0}}) begin
      thresh_clamp_s = CNT_W'(1);
    end else begin
      thresh_clamp_s = cfg_thresh;
    end
  end

  // Run-control FSM with registered status outputs, config and detector state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      match_r     <= 1'b0;
      match_cnt_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
      hist_r      <= {(MAX_LEN-1){1'b0}};
      fill_r      <= {LEN_W{1'b0}};
      win_cnt_r   <= {WIN_W{1'b0}};
      pat_r       <= PAT_RST;
      len_r       <= LEN_W'(3);
      thresh_r    <= CNT_W'(1);
      window_r    <= {WIN_W{1'b0}};
    end else if (abort) begin
      // match_cnt is deliberately left alone so the host can read it back.
      state_r   <= ST_IDLE;
      match_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          match_r <= 1'b0;
          done_r  <= 1'b0;
          if (data_valid) begin
            hist_r    <= hist_next_s[MAX_LEN-2:0];
            fill_r    <= fill_next_s;
            win_cnt_r <= win_next_s;
            if (hit_s) begin
              match_r     <= 1'b1;
              match_cnt_r <= cnt_inc_s;
            end
            // Threshold has priority over window expiry on the same sample.
            if (thr_hit_s) begin
`ifdef SEQDET_CTRL_AUTORESTART_EN
              match_cnt_r <= {CNT_W{1'b0}};
              win_cnt_r   <= {WIN_W{1'b0}};
              done_r      <= 1'b1;
`else
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
`endif
            end else if (exp_hit_s) begin
              state_r   <= ST_EXPIRE;
              busy_r    <= 1'b0;
              timeout_r <= 1'b1;
            end
          end
        end
        ST_IDLE, ST_DONE, ST_EXPIRE: begin
          match_r <= 1'b0;
          if (cfg_we && (state_r == ST_IDLE)) begin
            pat_r    <= cfg_pattern;
            len_r    <= len_clamp_s;
            thresh_r <= thresh_clamp_s;
            window_r <= cfg_window;
          end
          if (start) begin
            state_r     <= ST_RUN;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
            hist_r      <= {(MAX_LEN-1){1'b0}};
            fill_r      <= {LEN_W{1'b0}};
            win_cnt_r   <= {WIN_W{1'b0}};
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          match_r   <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_thresh;
  logic [WIN_W-1:0]   cfg_window;
  logic               start;
  logic               abort;
  logic               data_valid;
  logic               data_in;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [1:0]         state;

  int checks = 0;
  int errors = 0;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh), .cfg_window(cfg_window), .start(start), .abort(abort),
    .data_valid(data_valid), .data_in(data_in), .match(match), .match_cnt(match_cnt),
    .busy(busy), .done(done), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: history of valid samples in a queue, counts as plain integers.
  bit         mdl_q[$];
  int         mdl_st, mdl_cnt, mdl_win, mdl_len, mdl_thr, mdl_window;
  bit         mdl_match;
  logic [7:0] mdl_pat;

  function automatic bit mdl_hit();
    int n = mdl_q.size();
    if (n < mdl_len) return 1'b0;
    for (int i = 0; i < mdl_len; i++)
      if (mdl_q[n-1-i] != mdl_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic mdl_edge();
    if (rst) begin
      mdl_st = 0; mdl_cnt = 0; mdl_win = 0; mdl_match = 1'b0; mdl_q.delete();
      mdl_pat = 8'b101; mdl_len = 3; mdl_thr = 1; mdl_window = 0;
    end else if (abort) begin
      mdl_st = 0; mdl_match = 1'b0;
    end else begin
      mdl_match = 1'b0;
      if (mdl_st == 0 && cfg_we) begin
        mdl_pat    = cfg_pattern;
        mdl_len    = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
        mdl_thr    = (cfg_thresh == 0) ? 1 : int'(cfg_thresh);
        mdl_window = int'(cfg_window);
      end
      if (mdl_st != 1) begin
        if (start) begin
          mdl_st = 1; mdl_q.delete(); mdl_cnt = 0; mdl_win = 0;
        end
      end else if (data_valid) begin
        mdl_q.push_back(data_in);
        if (mdl_q.size() > 32) void'(mdl_q.pop_front());
        mdl_win++;
        if (mdl_hit()) begin
          mdl_match = 1'b1;
          if (mdl_cnt < 255) mdl_cnt++;
        end
        if (mdl_match && mdl_cnt >= mdl_thr) mdl_st = 2;
        else if (mdl_window != 0 && mdl_win >= mdl_window) mdl_st = 3;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_thresh = 8'd0;
    cfg_window = 16'd0; start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t,
                        input logic [15:0] w);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t; cfg_window = w;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic sample(input logic b);
    data_valid = 1'b1; data_in = b; tick(); data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++;
    if ({state, match, busy, done, timeout} !== 6'b0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: state=%b match=%b busy=%b done=%b timeout=%b cnt=%0d expected all zero",
               state, match, busy, done, timeout, match_cnt);
    end
  endtask

  task automatic test_default_101();
    logic [4:0] seq = 5'b10101;
    int pulses = 0;
    do_start();
    checks++;
    if (state !== 2'b01 || busy !== 1'b1) begin
      errors++; $display("FAIL start_run: state=%b busy=%b expected 01/1", state, busy);
    end
    for (int i = 4; i >= 0; i--) begin
      sample(seq[i]);
      if (match) pulses++;
      if (i == 2) begin
        checks++;
        if (match !== 1'b1 || match_cnt !== 8'd1 || state !== 2'b10 || done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL default_101_done: match=%b cnt=%0d state=%b done=%b busy=%b expected 1/1/10/1/0",
                   match, match_cnt, state, done, busy);
        end
      end
    end
    checks++;
    if (pulses !== 1 || match_cnt !== 8'd1 || state !== 2'b10) begin
      errors++;
      $display("FAIL default_101_hold: pulses=%0d cnt=%0d state=%b expected 1/1/10", pulses, match_cnt, state);
    end
  endtask

  task automatic test_overlap_1101();
    logic [9:0] seq = 10'b1101101101;
    int pulses = 0;
    do_abort();
    do_cfg(8'b1101, 4'd4, 8'd3, 16'd0);
    do_start();
    for (int i = 9; i >= 0; i--) begin
      sample(seq[i]);
      if (match) pulses++;
      if (i == 1) begin
        checks++;
        if (state !== 2'b01 || match_cnt !== 8'd2) begin
          errors++; $display("FAIL overlap_pre: state=%b cnt=%0d expected 01/2", state, match_cnt);
        end
      end
    end
    checks++;
    if (pulses !== 3 || match_cnt !== 8'd3 || state !== 2'b10 || done !== 1'b1) begin
      errors++;
      $display("FAIL overlap_1101: pulses=%0d cnt=%0d state=%b done=%b expected 3/3/10/1",
               pulses, match_cnt, state, done);
    end
  endtask

  task automatic test_window_expire();
    logic [5:0] seq = 6'b100000;
    do_abort();
    do_cfg(8'b101, 4'd3, 8'd2, 16'd6);
    do_start();
    for (int i = 5; i >= 0; i--) begin
      sample(seq[i]);
      if (i == 1) begin
        checks++;
        if (state !== 2'b01) begin
          errors++; $display("FAIL window_pre: state=%b expected 01", state);
        end
      end
    end
    checks++;
    if (state !== 2'b11 || timeout !== 1'b1 || match_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL window_expire: state=%b timeout=%b cnt=%0d busy=%b done=%b expected 11/1/0/0/0",
               state, timeout, match_cnt, busy, done);
    end
  endtask

  task automatic test_simul_boundary();
    do_abort();
    do_cfg(8'b101, 4'd3, 8'd1, 16'd3);
    do_start();
    sample(1'b1); sample(1'b0); sample(1'b1);
    checks++;
    if (state !== 2'b10 || done !== 1'b1 || timeout !== 1'b0 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL done_beats_expire: state=%b done=%b timeout=%b cnt=%0d expected 10/1/0/1",
               state, done, timeout, match_cnt);
    end
  endtask

  task automatic test_valid_gaps();
    int pulses = 0;
    do_abort();
    do_cfg(8'b101, 4'd3, 8'd2, 16'd0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      data_valid = (i % 2 == 0);
      data_in = (i == 0 || i == 4) ? 1'b1 : ((i == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
      tick();
      if (match) pulses++;
    end
    data_valid = 1'b0;
    checks++;
    if (pulses !== 1 || match_cnt !== 8'd1 || state !== 2'b01) begin
      errors++;
      $display("FAIL valid_gaps: pulses=%0d cnt=%0d state=%b expected 1/1/01", pulses, match_cnt, state);
    end
    // Write attempted mid-run: pattern 111 with threshold 1 must not take effect.
    do_cfg(8'b111, 4'd3, 8'd1, 16'd0);
    sample(1'b0); sample(1'b1);
    checks++;
    if (match_cnt !== 8'd2 || state !== 2'b10) begin
      errors++;
      $display("FAIL cfg_ignored_in_run: cnt=%0d state=%b expected 2/10", match_cnt, state);
    end
  endtask

  task automatic test_abort();
    logic [4:0] seq = 5'b10101;
    do_abort();
    do_cfg(8'b101, 4'd3, 8'd5, 16'd0);
    do_start();
    for (int i = 4; i >= 0; i--) sample(seq[i]);
    do_abort();
    checks++;
    if (state !== 2'b00 || busy !== 1'b0 || match_cnt !== 8'd2 || match !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid_run: state=%b busy=%b cnt=%0d match=%b expected 00/0/2/0",
               state, busy, match_cnt, match);
    end
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    checks++;
    if (state !== 2'b00 || busy !== 1'b0 || match_cnt !== 8'd2) begin
      errors++;
      $display("FAIL abort_beats_start: state=%b busy=%b cnt=%0d expected 00/0/2", state, busy, match_cnt);
    end
  endtask

  task automatic test_clamp();
    do_cfg(8'b1, 4'd0, 8'd0, 16'd0);
    do_start();
    sample(1'b0);
    checks++;
    if (match !== 1'b0 || state !== 2'b01) begin
      errors++; $display("FAIL clamp_nomatch: match=%b state=%b expected 0/01", match, state);
    end
    sample(1'b1);
    checks++;
    if (match !== 1'b1 || match_cnt !== 8'd1 || state !== 2'b10) begin
      errors++;
      $display("FAIL clamp_len0_thr0: match=%b cnt=%0d state=%b expected 1/1/10", match, match_cnt, state);
    end
  endtask

  task automatic test_rst_mid_run();
    do_abort();
    do_cfg(8'b11, 4'd2, 8'd9, 16'd20);
    do_start();
    sample(1'b1); sample(1'b1); sample(1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({state, match, busy, done, timeout} !== 6'b0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_run: state=%b match=%b busy=%b done=%b timeout=%b cnt=%0d expected all zero",
               state, match, busy, done, timeout, match_cnt);
    end
    do_start();
    sample(1'b1); sample(1'b0); sample(1'b1);
    checks++;
    if (match !== 1'b1 || match_cnt !== 8'd1 || state !== 2'b10) begin
      errors++;
      $display("FAIL rst_restores_cfg: match=%b cnt=%0d state=%b expected 1/1/10", match, match_cnt, state);
    end
  endtask

  task automatic test_random();
    drive_idle();
    rst = 1'b1; mdl_edge(); tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      abort  = ($urandom_range(0, 99) == 0);
      start  = (mdl_st != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_pattern = 8'($urandom());
      cfg_len     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      cfg_thresh  = 8'($urandom_range(0, 5));
      cfg_window  = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      data_valid  = ($urandom_range(0, 3) != 0);
      data_in     = 1'($urandom_range(0, 1));
      mdl_edge();
      tick();
      checks++;
      if (state !== mdl_st[1:0] || match !== mdl_match || match_cnt !== mdl_cnt[7:0] ||
          busy !== (mdl_st == 1) || done !== (mdl_st == 2) || timeout !== (mdl_st == 3)) begin
        errors++;
        $display("FAIL random_cycle_%0d: state=%b match=%b cnt=%0d busy=%b done=%b timeout=%b expected state=%0d match=%b cnt=%0d",
                 c, state, match, match_cnt, busy, done, timeout, mdl_st, mdl_match, mdl_cnt);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_default_101();
    test_overlap_1101();
    test_window_expire();
    test_simul_boundary();
    test_valid_gaps();
    test_abort();
    test_clamp();
    test_rst_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
